// File: rtl/differentiator.sv
// -----------------------------------------------------------------------------
// differentiator
//   Finite-difference differentiator on IEEE-754 single-precision samples:
//       out = (x[n] - x[n-1]) * 2^DT_SHIFT
//   Stage 1 registers the difference d, and stage 2 registers the scaled result.
//   Multiplying by 2^DT_SHIFT is an exponent add that saturates to a signed
//   infinity. It also flushes zero and denormal differences to +0.
//
// Ports
//   clk        clock
//   reset      synchronous, active-high reset
//   in_valid   one-cycle strobe, x carries a new sample
//   x          IEEE-754 single sample
//   out_valid  one-cycle pulse when out/overflow are updated
//   out        IEEE-754 single derivative, holds between pulses
//   overflow   out is saturated or non-finite, updates with out_valid
//   primed     a previous sample is held, so derivatives will be produced
//
// The file also contains `add`, a combinational single-precision adder.
// It rounds to nearest-even and supports denormals.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// add
//   Combinational IEEE-754 single-precision adder.
//   o_sum = i_a + i_b, rounded to nearest-even.
//   NaN operands and inf + (-inf) return the quiet NaN 32'h7FC00000.
//   Results that are too large saturate to a signed infinity.
// Ports
//   i_a, i_b   operands
//   o_sum      rounded sum
// -----------------------------------------------------------------------------
module add (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);

    // Count the leading zeros of a 27-bit value. An all-zero value returns 27.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) begin
                n = 5'(26 - i);
            end
        end
        return n;
    endfunction

    function automatic logic is_nan(input logic [31:0] f);
        return (&f[30:23]) & (|f[22:0]);
    endfunction

    function automatic logic is_inf(input logic [31:0] f);
        return (&f[30:23]) & ~(|f[22:0]);
    endfunction

    logic [31:0] w_big;
    logic [31:0] w_small;
    logic [7:0]  w_eb;
    logic [7:0]  w_es;
    logic [7:0]  w_ediff;
    logic [26:0] w_mb;
    logic [26:0] w_ms;
    logic [26:0] w_ms_sh;
    logic        w_sub;
    logic [27:0] w_sum;
    logic [9:0]  w_exp;
    logic [4:0]  w_lz;
    logic [4:0]  w_shift;
    logic [26:0] w_norm;
    logic [7:0]  w_exp_field;
    logic        w_rnd;
    logic [30:0] w_packed;

    // Align, add or subtract, normalise and round. Special operands are resolved last.
    always_comb begin
        w_big       = i_a;
        w_small     = i_b;
        w_eb        = 8'd0;
        w_es        = 8'd0;
        w_ediff     = 8'd0;
        w_mb        = 27'd0;
        w_ms        = 27'd0;
        w_ms_sh     = 27'd0;
        w_sub       = 1'b0;
        w_sum       = 28'd0;
        w_exp       = 10'd0;
        w_lz        = 5'd0;
        w_shift     = 5'd0;
        w_norm      = 27'd0;
        w_exp_field = 8'd0;
        w_rnd       = 1'b0;
        w_packed    = 31'd0;
        o_sum       = 32'd0;

        // Put the larger magnitude in w_big, so that subtraction never goes negative.
        if (i_a[30:0] >= i_b[30:0]) begin
            w_big   = i_a;
            w_small = i_b;
        end else begin
            w_big   = i_b;
            w_small = i_a;
        end

        // Denormals use exponent 1 and have no hidden bit.
        // Each mantissa is followed by three guard/round/sticky bits.
        w_eb    = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
        w_es    = (w_small[30:23] == 8'd0) ? 8'd1 : w_small[30:23];
        w_mb    = {|w_big[30:23], w_big[22:0], 3'b000};
        w_ms    = {|w_small[30:23], w_small[22:0], 3'b000};
        w_ediff = w_eb - w_es;

        // Bits shifted out of the smaller operand are collapsed into the sticky bit.
        if (w_ediff >= 8'd27) begin
            w_ms_sh = {26'd0, |w_ms};
        end else begin
            w_ms_sh = (w_ms >> w_ediff) | {26'd0, |(w_ms & ~({27{1'b1}} << w_ediff))};
        end

        w_sub = w_big[31] ^ w_small[31];
        if (w_sub) begin
            w_sum = {1'b0, w_mb} - {1'b0, w_ms_sh};
        end else begin
            w_sum = {1'b0, w_mb} + {1'b0, w_ms_sh};
        end

        w_exp = {2'b00, w_eb};
        if (w_sum[27]) begin
            // Carry out: shift right by one and keep the lost bit as sticky.
            w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
            w_exp  = w_exp + 10'd1;
        end else begin
            // Shift left, but stop at exponent 1, where the result becomes denormal.
            w_lz = lzc27(w_sum[26:0]);
            if (w_exp > {5'd0, w_lz}) begin
                w_shift = w_lz;
            end else begin
                w_shift = 5'(w_exp - 10'd1);
            end
            w_norm = w_sum[26:0] << w_shift;
            w_exp  = w_exp - {5'd0, w_shift};
        end

        // A missing hidden bit means a denormal, which uses exponent field 0.
        // A rounding carry propagates into the exponent field. This also turns
        // a denormal into the smallest normal, and turns 254 into infinity.
        w_exp_field = w_norm[26] ? w_exp[7:0] : 8'd0;
        w_rnd       = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_packed    = {w_exp_field, w_norm[25:3]} + {30'd0, w_rnd};

        if (w_sum == 28'd0) begin
            o_sum = {w_big[31] & w_small[31], 31'd0};
        end else if (w_exp >= 10'd255) begin
            o_sum = {w_big[31], 8'hFF, 23'd0};
        end else begin
            o_sum = {w_big[31], w_packed};
        end

        if (is_nan(i_a) || is_nan(i_b)) begin
            o_sum = 32'h7FC00000;
        end else if (is_inf(i_a) && is_inf(i_b) && (i_a[31] != i_b[31])) begin
            o_sum = 32'h7FC00000;
        end else if (is_inf(i_a)) begin
            o_sum = i_a;
        end else if (is_inf(i_b)) begin
            o_sum = i_b;
        end else begin
            o_sum = o_sum;
        end
    end

endmodule

module differentiator #(
    parameter int DT_SHIFT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] x,
    output logic        out_valid,
    output logic [31:0] out,
    output logic        overflow,
    output logic        primed
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_load_s1;
    logic [31:0] r_x_prev;
    logic [31:0] r_d;
    logic        r_s1_valid;
    logic [31:0] r_out;
    logic        r_overflow;
    logic        r_out_valid;

    logic [31:0] w_neg_prev;
    logic [31:0] w_diff;
    logic [31:0] w_d;
    logic [7:0]  w_e;
    logic [8:0]  w_e_sum;
    logic [31:0] w_scaled;
    logic        w_scaled_ovf;

    // Subtract by adding the previous sample with its sign flipped.
    assign w_neg_prev = {~r_x_prev[31], r_x_prev[30:0]};

    add u_add (
        .i_a   (x),
        .i_b   (w_neg_prev),
        .o_sum (w_diff)
    );

    // Identical bit patterns give +0 directly. This includes identical NaNs.
    assign w_d = (x == r_x_prev) ? 32'h0 : w_diff;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, and whether this strobe produces a derivative.
    always_comb begin
        w_state_next = r_state;
        w_load_s1    = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (in_valid) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_RUN: begin
                w_state_next = ST_RUN;
                if (in_valid) begin
                    w_load_s1 = 1'b1;
                end else begin
                    w_load_s1 = 1'b0;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
                w_load_s1    = 1'b0;
            end
        endcase
    end

    // Stage 1: hold the previous sample and register the difference.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x_prev   <= 32'h0;
            r_d        <= 32'h0;
            r_s1_valid <= 1'b0;
        end else begin
            if (in_valid) begin
                r_x_prev <= x;
            end
            if (w_load_s1) begin
                r_d <= w_d;
            end
            r_s1_valid <= w_load_s1;
        end
    end

    // Compute the exponent sum 9 bits wide, so that saturation is detected before wrap.
    assign w_e     = r_d[30:23];
    assign w_e_sum = {1'b0, w_e} + 9'(DT_SHIFT);

    // Stage 2 combinational: scale by 2^DT_SHIFT, with flush and saturation.
    always_comb begin
        w_scaled     = 32'h0;
        w_scaled_ovf = 1'b0;
        if (w_e == 8'd0) begin
            w_scaled     = 32'h0;
            w_scaled_ovf = 1'b0;
        end else if (w_e == 8'hFF) begin
            w_scaled     = r_d;
            w_scaled_ovf = 1'b1;
        end else if (w_e_sum >= 9'd255) begin
            w_scaled     = {r_d[31], 8'hFF, 23'd0};
            w_scaled_ovf = 1'b1;
        end else begin
            w_scaled     = {r_d[31], w_e_sum[7:0], r_d[22:0]};
            w_scaled_ovf = 1'b0;
        end
    end

    // Stage 2 register. out and overflow only change on a valid stage-1 result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out       <= 32'h0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out      <= w_scaled;
                r_overflow <= w_scaled_ovf;
            end
        end
    end

    assign out       = r_out;
    assign overflow  = r_overflow;
    assign out_valid = r_out_valid;
    assign primed    = (r_state == ST_RUN);

endmodule

// File: tb/tb_differentiator.sv
module tb_differentiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] x;
    logic        out_valid;
    logic [31:0] out_s;
    logic        overflow;
    logic        primed;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;

    exp_t        q[$];
    logic [31:0] prev;
    logic [31:0] nx;
    logic        v;

    differentiator #(.DT_SHIFT(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .x         (x),
        .out_valid (out_valid),
        .out       (out_s),
        .overflow  (overflow),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic do_reset;
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic strobe(input logic [31:0] val);
        in_valid = 1'b1;
        x        = val;
        tick();
        in_valid = 1'b0;
    endtask

    // Strobe one sample, then expect its derivative on the following sample.
    task automatic strobe_expect(input string tag, input logic [31:0] val,
                                 input logic [31:0] exp_out, input logic exp_ovf);
        strobe(val);
        chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        tick();
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_out"}, out_s, exp_out);
        chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
    endtask

    // Reference model: single to real. Normal or zero values only.
    function automatic real s2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:0] == 31'd0) return 0.0;
        d = {b[31], 11'({3'b000, b[30:23]}) + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Reference model: real to single, round to nearest-even, normal range only.
    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        logic [52:0] m;
        logic [24:0] m24;
        logic [28:0] rest;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d    = $realtobits(r);
        e    = d[62:52];
        m    = {1'b1, d[51:0]};
        m24  = {1'b0, m[52:29]};
        rest = m[28:0];
        if (rest > 29'h10000000 || (rest == 29'h10000000 && m24[0])) m24 = m24 + 25'd1;
        if (m24[24]) begin
            m24 = m24 >> 1;
            e   = e + 11'd1;
        end
        return {d[63], 8'(e - 11'd896), m24[22:0]};
    endfunction

    // Random sample within +/-10 binades of ref_v, so that the exact difference fits a double.
    function automatic logic [31:0] rnd_near(input logic [31:0] ref_v);
        int e;
        e = int'(ref_v[30:23]) + int'($urandom_range(20)) - 10;
        if (e < 100) e = 100;
        if (e > 160) e = 160;
        return {1'($urandom), 8'(e), 23'($urandom)};
    endfunction

    task automatic check_stream;
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("rnd_valid", {31'd0, out_valid}, 32'd1);
            chk("rnd_out", out_s, q[0].val);
            chk("rnd_ovf", {31'd0, overflow}, 32'd0);
            void'(q.pop_front());
        end else begin
            chk("rnd_idle", {31'd0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        x        = 32'h0;
        do_reset();
        chk("rst_out", out_s, 32'h0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_primed", {31'd0, primed}, 32'd0);

        // The first sample primes the block and produces no output.
        strobe(32'h3F800000);
        chk("prime_primed", {31'd0, primed}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("prime_novalid", {31'd0, out_valid}, 32'd0);
            chk("prime_out", out_s, 32'h0);
            tick();
        end

        // 2.0 - 1.0 = 1.0, which scales to 1024.0.
        strobe_expect("d2m1", 32'h40000000, 32'h44800000, 1'b0);
        tick();
        chk("pulse_once", {31'd0, out_valid}, 32'd0);
        chk("hold_out", out_s, 32'h44800000);

        // Back-to-back strobes.
        do_reset();
        strobe(32'h3F800000);
        in_valid = 1'b1;
        x        = 32'h40000000;
        tick();
        x = 32'h3FC00000;
        tick();
        in_valid = 1'b0;
        chk("b2b_v1", {31'd0, out_valid}, 32'd1);
        chk("b2b_o1", out_s, 32'h44800000);
        tick();
        chk("b2b_v2", {31'd0, out_valid}, 32'd1);
        chk("b2b_o2", out_s, 32'hC4000000);
        tick();
        chk("b2b_end", {31'd0, out_valid}, 32'd0);

        // Equal samples give +0.
        strobe_expect("equal", 32'h3FC00000, 32'h00000000, 1'b0);

        // A negative result, then a denormal difference that is flushed to +0.
        do_reset();
        strobe(32'h3F800000);
        strobe_expect("to2", 32'h40000000, 32'h44800000, 1'b0);
        strobe_expect("to0", 32'h00000000, 32'hC5000000, 1'b0);
        strobe_expect("denorm", 32'h00000001, 32'h00000000, 1'b0);

        // Saturation, clearing, infinity and NaN.
        do_reset();
        strobe(32'h3F800000);
        strobe_expect("sat", 32'h7F000000, 32'h7F800000, 1'b1);
        strobe_expect("sat_clr", 32'h7F000000, 32'h00000000, 1'b0);
        strobe_expect("inf", 32'h7F800000, 32'h7F800000, 1'b1);
        strobe_expect("nan", 32'h7FC00000, 32'h7FC00000, 1'b1);

        // A reset while a result is in flight discards it.
        do_reset();
        strobe(32'h3F800000);
        strobe(32'h40000000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_primed", {31'd0, primed}, 32'd0);
        chk("mid_out", out_s, 32'h0);
        tick();
        chk("mid_valid2", {31'd0, out_valid}, 32'd0);
        strobe(32'h40400000);
        chk("mid_reprime", {31'd0, primed}, 32'd1);
        tick();
        chk("mid_nofirst", {31'd0, out_valid}, 32'd0);
        tick();
        chk("mid_nofirst2", {31'd0, out_valid}, 32'd0);
        strobe_expect("mid_next", 32'h40A00000, 32'h45000000, 1'b0);

        // Random stream checked against a real-arithmetic model.
        do_reset();
        prev = {1'($urandom), 8'(110 + $urandom_range(40)), 23'($urandom)};
        strobe(prev);
        for (int i = 0; i < 300; i++) begin
            v  = ($urandom_range(3) != 0);
            nx = rnd_near(prev);
            in_valid = v;
            x        = nx;
            if (v) begin
                q.push_back('{cyc + 2, r2s((s2r(nx) - s2r(prev)) * 1024.0)});
                prev = nx;
            end
            tick();
            check_stream();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_stream();
        end
        chk("rnd_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/differentiator.md
Name: differentiator

Overview:
- Sampled finite-difference differentiator on IEEE-754 single-precision data: out = (x[n] - x[n-1]) / dt, with dt = 2^-DT_SHIFT.
- Inverse counterpart of the float integrator (x*dt + int_x). It recovers rates, e.g. velocity from a position/length signal, at the model's sample strobe.
- Subtraction uses the team's combinational float adder `add`, with the previous sample sign-flipped. Division by dt is an exponent add with saturation.

Parameters:
- DT_SHIFT, 10, log2(1/dt); scale factor is 2^DT_SHIFT, legal range 1..127.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  one-cycle strobe; x is a new sample
- x  input  32  IEEE-754 single sample
- out_valid  output  1  one-cycle pulse; out/overflow are updated
- out  output  32  IEEE-754 single derivative; holds between pulses
- overflow  output  1  out saturated or non-finite; updates with out_valid
- primed  output  1  previous sample held; derivatives will be produced

Behaviour:
- Reset is synchronous and active-high. reset is sampled on clk.
- Reset values: out=32'h0, out_valid=0, overflow=0, primed=0, internal x_prev=0, stage-1 valid=0.
- Reset has priority over in_valid in the same cycle.
- FSM states:
  - EMPTY (primed=0): on in_valid, x_prev<=x, go to RUN. No out_valid is produced, because the first sample has no derivative.
  - RUN (primed=1): on in_valid, load stage 1 and update x_prev<=x. Stay in RUN.
- Stage 1 (register d, s1_valid):
  - d = add(x, {~x_prev[31], x_prev[30:0]}).
  - If x == x_prev bitwise, force d = +0 and do not rely on the adder.
- Stage 2 (scale, register out/overflow, pulse out_valid); e = d[30:23]:
  - e==0 (zero or denormal): out=32'h0, overflow=0. Denormals are flushed and the sign is dropped.
  - e==255 (inf/NaN): out=d unchanged, overflow=1.
  - e+DT_SHIFT >= 255: out={d[31],8'hFF,23'h0} (signed inf), overflow=1. Compute the sum 9 bits wide.
  - Otherwise: out={d[31], e+DT_SHIFT, d[22:0]}, overflow=0.
- Latency and throughput:
  - in_valid at cycle N in RUN gives out_valid at N+2.
  - in_valid every cycle is supported, giving one result per cycle with no stalls and no backpressure.
- out_valid is high for exactly one cycle per accepted RUN sample. out and overflow hold their last value otherwise.
- Reset mid-operation: in-flight stage-1/stage-2 results are discarded, with no out_valid after reset. The FSM returns to EMPTY, and the next sample is treated as the first.
- NaN/inf inputs propagate through the adder per `add` semantics, then follow the e==255 rule.

Test Plan:
- Reset, then in_valid with x=32'h3F800000 (1.0): no out_valid for 4 cycles; primed=1 one cycle after the strobe; out stays 32'h0.
- Primed with 1.0, then x=32'h40000000 (2.0): two cycles later out_valid=1 for one cycle, out=32'h44800000 (1024.0), overflow=0.
- Back-to-back strobes with 2.0 then 1.5 (32'h3FC00000) after priming with 1.0: out_valid on two consecutive cycles, out=32'h44800000 then 32'hC4000000 (-512.0).
- Equal samples 1.5, 1.5: out=32'h00000000, overflow=0. Tiny difference of 32'h00000001 versus 0 (denormal): out=32'h0.
- Primed with 1.0, then x=32'h7F000000: d exponent 254, 254+10 > 254, so out=32'h7F800000, overflow=1.
- Strobe at N in RUN, reset at N+1: no out_valid at N+2, primed=0. The next strobe produces no output; the following strobe produces a derivative relative to it.
